// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_sequencer
// Description : Five-stage MIPS pipeline sequencer: PC/IF-ID write enables,
//               flushes, load-use stall, redirect, freeze, HALT drain and an
//               active-cycle counter. Optional single-step support is
//               compiled in when the SEQ_STEP_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_step,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_id_halt,
    input  logic             i_ex_mem_read,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_ex_redirect,
    output logic             o_pc_we,
    output logic             o_ifid_we,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_pipe_en,
    output logic             o_halted,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam logic [1:0] c_ST_IDLE   = 2'b00;
    localparam logic [1:0] c_ST_RUN    = 2'b01;
    localparam logic [1:0] c_ST_DRAIN  = 2'b10;
    localparam logic [1:0] c_ST_HALTED = 2'b11;

    localparam logic [7:0] c_DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    logic [1:0]       r_state;
    logic [7:0]       r_drain_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic w_load_use;
    logic w_advance;
    logic w_pc_we;
    logic w_ifid_we;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_pipe_en;
    logic w_halted;
    logic w_enter_drain;

    // A load into r0 never creates a real dependency, so it never stalls.
    assign w_load_use = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                        ((i_ex_rt == i_id_rs) ||
                         (i_id_uses_rt && (i_ex_rt == i_id_rt)));

`ifdef SEQ_STEP_EN
    logic r_step_prev;
    logic w_step_rise;

    assign w_step_rise = i_step && !r_step_prev;
    assign w_advance   = i_enable || w_step_rise;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_step_prev <= 1'b0;
        end else begin
            r_step_prev <= i_step;
        end
    end
`else
    logic w_step_unused;

    assign w_step_unused = i_step;
    assign w_advance     = i_enable;
`endif

    always_comb begin
        w_pc_we       = 1'b0;
        w_ifid_we     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_pipe_en     = 1'b0;
        w_halted      = 1'b0;
        w_enter_drain = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (i_ex_redirect) begin
                    // The ID instruction is on the wrong path; redirect wins.
                    w_pc_we      = 1'b1;
                    w_ifid_we    = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    w_pipe_en    = 1'b1;
                end else if (w_load_use) begin
                    w_idex_flush = 1'b1;
                    w_pipe_en    = 1'b1;
                end else if (i_id_halt) begin
                    w_idex_flush  = 1'b1;
                    w_pipe_en     = 1'b1;
                    w_enter_drain = 1'b1;
                end else if (w_advance) begin
                    w_pc_we   = 1'b1;
                    w_ifid_we = 1'b1;
                    w_pipe_en = 1'b1;
                end
            end
            c_ST_DRAIN: begin
                w_idex_flush = 1'b1;
                w_pipe_en    = 1'b1;
            end
            c_ST_HALTED: begin
                w_halted = 1'b1;
            end
            default: begin
            end
        endcase
        // Everything is held quiet while reset is asserted.
        if (!i_rst_n) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_ifid_flush  = 1'b0;
            w_idex_flush  = 1'b0;
            w_pipe_en     = 1'b0;
            w_halted      = 1'b0;
            w_enter_drain = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= c_ST_IDLE;
            r_drain_cnt <= 8'd0;
            r_cycle_cnt <= '0;
        end else begin
            if (w_pipe_en && ((r_state == c_ST_RUN) || (r_state == c_ST_DRAIN))) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (i_enable) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (w_enter_drain) begin
                        r_state     <= c_ST_DRAIN;
                        r_drain_cnt <= c_DRAIN_LOAD;
                    end
                end
                c_ST_DRAIN: begin
                    if (r_drain_cnt == 8'd0) begin
                        r_state <= c_ST_HALTED;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_HALTED;
                end
            endcase
        end
    end

    assign o_pc_we      = w_pc_we;
    assign o_ifid_we    = w_ifid_we;
    assign o_ifid_flush = w_ifid_flush;
    assign o_idex_flush = w_idex_flush;
    assign o_pipe_en    = w_pipe_en;
    assign o_halted     = w_halted;
    assign o_state      = r_state;
    assign o_cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_sequencer
// Description : Directed self-checking bench for pipeline_sequencer
//               (step expectations follow the SEQ_STEP_EN macro).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        step;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_halt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_redirect;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        pipe_en;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;

    int checks;
    int errors;
    logic [31:0] exp_cnt;

    pipeline_sequencer #(
        .DRAIN_CYCLES(3),
        .CNT_W(32)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_step       (step),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_uses_rt (id_uses_rt),
        .i_id_halt    (id_halt),
        .i_ex_mem_read(ex_mem_read),
        .i_ex_rt      (ex_rt),
        .i_ex_redirect(ex_redirect),
        .o_pc_we      (pc_we),
        .o_ifid_we    (ifid_we),
        .o_ifid_flush (ifid_flush),
        .o_idex_flush (idex_flush),
        .o_pipe_en    (pipe_en),
        .o_halted     (halted),
        .o_state      (state),
        .o_cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        step        = 1'b0;
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_uses_rt  = 1'b0;
        id_halt     = 1'b0;
        ex_mem_read = 1'b0;
        ex_rt       = 5'd0;
        ex_redirect = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        clear_inputs();
        tick();
        tick();
        #1;
        checks++;
        if (state !== 2'b00) begin
            errors++; $display("FAIL reset_state actual=%0d required=0", state);
        end
        checks++;
        if (cycle_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt actual=%0d required=0", cycle_cnt);
        end
        checks++;
        if ({pc_we, ifid_we, pipe_en, ifid_flush, idex_flush, halted} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs actual=%b required=000000",
                     {pc_we, ifid_we, pipe_en, ifid_flush, idex_flush, halted});
        end
    endtask

    task automatic test_run();
        rst_n  = 1'b1;
        enable = 1'b1;
        #1;
        checks++;
        if (pc_we !== 1'b0 || pipe_en !== 1'b0) begin
            errors++; $display("FAIL idle_enables actual=%b%b required=00", pc_we, pipe_en);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({state, pc_we, ifid_we, pipe_en, ifid_flush, idex_flush} !== 7'b01_111_00) begin
                errors++;
                $display("FAIL run_cycle%0d actual=%b required=0111100", i,
                         {state, pc_we, ifid_we, pipe_en, ifid_flush, idex_flush});
            end
            tick();
        end
        exp_cnt = 32'd10;
        checks++;
        if (cycle_cnt !== exp_cnt) begin
            errors++; $display("FAIL run_cnt actual=%0d required=%0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_load_use();
        // rs match -> stall
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        checks++;
        if ({pc_we, ifid_we, idex_flush, pipe_en, ifid_flush} !== 5'b00110) begin
            errors++;
            $display("FAIL lu_rs actual=%b required=00110", {pc_we, ifid_we, idex_flush, pipe_en, ifid_flush});
        end
        tick(); exp_cnt++;
        // load into r0 -> no stall
        ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        checks++;
        if ({pc_we, ifid_we, idex_flush} !== 3'b110) begin
            errors++; $display("FAIL lu_r0 actual=%b required=110", {pc_we, ifid_we, idex_flush});
        end
        tick(); exp_cnt++;
        // rt match but rt not read -> no stall
        ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        #1;
        checks++;
        if ({pc_we, ifid_we, idex_flush} !== 3'b110) begin
            errors++; $display("FAIL lu_rt_unused actual=%b required=110", {pc_we, ifid_we, idex_flush});
        end
        tick(); exp_cnt++;
        // rt match and rt read -> stall
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if ({pc_we, ifid_we, idex_flush} !== 3'b001) begin
            errors++; $display("FAIL lu_rt_used actual=%b required=001", {pc_we, ifid_we, idex_flush});
        end
        tick(); exp_cnt++;
        clear_inputs();
        #1;
        checks++;
        if (cycle_cnt !== exp_cnt || state !== 2'b01) begin
            errors++; $display("FAIL lu_cnt actual=%0d/%0d required=%0d/1", cycle_cnt, state, exp_cnt);
        end
    endtask

    task automatic test_redirect();
        ex_redirect = 1'b1;
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
        id_halt = 1'b1;
        #1;
        checks++;
        if ({pc_we, ifid_we, ifid_flush, idex_flush, pipe_en} !== 5'b11111) begin
            errors++;
            $display("FAIL redirect_outputs actual=%b required=11111",
                     {pc_we, ifid_we, ifid_flush, idex_flush, pipe_en});
        end
        tick(); exp_cnt++;
        clear_inputs();
        #1;
        checks++;
        if (state !== 2'b01) begin
            errors++; $display("FAIL redirect_state actual=%0d required=1", state);
        end
    endtask

    task automatic test_freeze();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({pc_we, ifid_we, pipe_en, ifid_flush, idex_flush} !== 5'b0) begin
                errors++;
                $display("FAIL freeze_cycle%0d actual=%b required=00000", i,
                         {pc_we, ifid_we, pipe_en, ifid_flush, idex_flush});
            end
            tick();
        end
        checks++;
        if (cycle_cnt !== exp_cnt || state !== 2'b01) begin
            errors++; $display("FAIL freeze_cnt actual=%0d/%0d required=%0d/1", cycle_cnt, state, exp_cnt);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (pc_we !== 1'b1 || pipe_en !== 1'b1) begin
            errors++; $display("FAIL resume actual=%b%b required=11", pc_we, pipe_en);
        end
        tick(); exp_cnt++;
    endtask

    task automatic test_step();
        int adv;
        int exp_adv;
`ifdef SEQ_STEP_EN
        exp_adv = 1;
`else
        exp_adv = 0;
`endif
        adv    = 0;
        enable = 1'b0;
        step   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (pc_we === 1'b1) adv++;
            tick();
        end
        exp_cnt = exp_cnt + 32'(exp_adv);
        checks++;
        if (adv !== exp_adv) begin
            errors++; $display("FAIL step_grants actual=%0d required=%0d", adv, exp_adv);
        end
        checks++;
        if (cycle_cnt !== exp_cnt) begin
            errors++; $display("FAIL step_cnt actual=%0d required=%0d", cycle_cnt, exp_cnt);
        end
        step = 1'b0;
        tick();
        enable = 1'b1;
    endtask

    task automatic test_halt_drain();
        id_halt = 1'b1;
        #1;
        checks++;
        if ({pc_we, ifid_we, idex_flush, pipe_en} !== 4'b0011) begin
            errors++; $display("FAIL halt_outputs actual=%b required=0011", {pc_we, ifid_we, idex_flush, pipe_en});
        end
        tick(); exp_cnt++;
        id_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enable      = i[0];
            ex_redirect = 1'b1;
            #1;
            checks++;
            if ({state, pipe_en, pc_we, ifid_flush, idex_flush} !== 6'b10_1001) begin
                errors++;
                $display("FAIL drain_cycle%0d actual=%b required=101001", i,
                         {state, pipe_en, pc_we, ifid_flush, idex_flush});
            end
            tick(); exp_cnt++;
        end
        ex_redirect = 1'b0;
        #1;
        checks++;
        if ({state, halted, pipe_en, pc_we} !== 5'b11_100) begin
            errors++; $display("FAIL halted_state actual=%b required=11100", {state, halted, pipe_en, pc_we});
        end
        for (int i = 0; i < 4; i++) begin
            enable = ~enable;
            tick();
        end
        #1;
        checks++;
        if (cycle_cnt !== exp_cnt || state !== 2'b11) begin
            errors++; $display("FAIL halted_frozen actual=%0d/%0d required=%0d/3", cycle_cnt, state, exp_cnt);
        end
    endtask

    task automatic test_reset_in_drain();
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        tick();
        id_halt = 1'b1;
        tick();
        id_halt = 1'b0;
        #1;
        checks++;
        if (state !== 2'b10 || cycle_cnt !== 32'd2) begin
            errors++; $display("FAIL pre_reset_drain actual=%0d/%0d required=2/2", state, cycle_cnt);
        end
        tick();
        rst_n = 1'b0;
        tick();
        #1;
        checks++;
        if (state !== 2'b00 || cycle_cnt !== 32'd0 || pipe_en !== 1'b0 || idex_flush !== 1'b0) begin
            errors++;
            $display("FAIL drain_reset actual=%0d/%0d/%b%b required=0/0/00", state, cycle_cnt, pipe_en, idex_flush);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 32'd0;
        rst_n   = 1'b0;
        enable  = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_run();
        test_load_use();
        test_redirect();
        test_freeze();
        test_step();
        test_halt_drain();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Sequences the five-stage MIPS pipeline around the decode/control logic: produces PC and stage-register write enables and flushes.
- Handles load-use stalls, flushes on redirects (jump or taken branch) resolved in EX, and run/freeze control from the debug unit.
- Drains the pipeline on HALT and counts active cycles for the debug unit.
- Sits beside the control unit; purely a controller, no data path.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN after HALT leaves ID (EX, MEM, WB)
- CNT_W, 32, width of active-cycle counter

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  synchronous reset, active low
- i_enable  in  1  debug-unit run request; 0 freezes the pipeline
- i_step  in  1  single-step request (used only with SEQ_STEP_EN)
- i_id_rs  in  5  RS field of the instruction in ID
- i_id_rt  in  5  RT field of the instruction in ID
- i_id_uses_rt  in  1  ID instruction reads RT as a source
- i_id_halt  in  1  ID holds a HALT instruction
- i_ex_mem_read  in  1  EX holds a load
- i_ex_rt  in  5  destination register of the load in EX
- i_ex_redirect  in  1  EX resolved a jump or taken branch this cycle
- o_pc_we  out  1  PC write enable
- o_ifid_we  out  1  IF/ID register write enable
- o_ifid_flush  out  1  IF/ID loads a NOP
- o_idex_flush  out  1  ID/EX loads a bubble
- o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB advance
- o_halted  out  1  pipeline fully drained
- o_state  out  2  00 IDLE, 01 RUN, 10 DRAIN, 11 HALTED
- o_cycle_cnt  out  CNT_W  cycles spent in RUN or DRAIN with o_pipe_en=1

Behaviour:
- Reset (i_rst_n=0 at an edge): state=IDLE, drain counter=0, o_cycle_cnt=0, step edge register=0.
- Output values during and after reset: o_pc_we, o_ifid_we and o_pipe_en = 0; both flushes = 0; o_halted = 0.
- Reset mid-RUN or mid-DRAIN: returns to IDLE the next edge and discards all state.
- Registered vs combinational: state and counters are registered. Control outputs are combinational from the current state and inputs (zero-cycle latency), so a stall applies in the same cycle the hazard is visible.

IDLE:
- All enables 0.
- i_enable=1 -> RUN.

RUN, evaluated in priority order (first match wins):
1. redirect
   - Condition: i_ex_redirect=1.
   - Outputs: o_pc_we=1, o_ifid_we=1, o_ifid_flush=1, o_idex_flush=1, o_pipe_en=1.
   - Overrides load-use and halt, because the ID instruction is on the wrong path.
2. load-use
   - Condition: i_ex_mem_read=1, i_ex_rt!=0, and (i_ex_rt==i_id_rs, or i_id_uses_rt=1 with i_ex_rt==i_id_rt).
   - Outputs: o_pc_we=0, o_ifid_we=0, o_idex_flush=1, o_pipe_en=1. One bubble only; the next cycle re-evaluates.
3. halt
   - Condition: i_id_halt=1.
   - Outputs: o_pc_we=0, o_ifid_we=0, o_idex_flush=1, o_pipe_en=1.
   - Next state DRAIN; drain counter loads DRAIN_CYCLES-1.
4. freeze
   - Condition: i_enable=0.
   - Outputs: all enables 0, no flush. State stays RUN.
5. normal
   - Outputs: o_pc_we=1, o_ifid_we=1, o_pipe_en=1, no flush.

DRAIN:
- Outputs: o_pc_we=0, o_ifid_we=0, o_idex_flush=1, o_pipe_en=1. Inputs are ignored, including i_enable and i_ex_redirect.
- Counter decrements each cycle; at 0 -> HALTED.
- DRAIN_CYCLES=0 is illegal; values 1..255 are supported (8-bit counter).

HALTED:
- All enables 0, o_halted=1.
- Exits only through reset.

o_cycle_cnt:
- Increments by 1 on every edge where o_pipe_en=1 and state is RUN or DRAIN.
- Wraps modulo 2^CNT_W.
- Frozen in IDLE and HALTED.

Optional Feature:
- Macro SEQ_STEP_EN.
- Defined:
  - i_step is edge-detected using a registered previous value.
  - In RUN with i_enable=0, a rising edge of i_step grants exactly one cycle of normal RUN behaviour (priority rules 1-3 and 5 apply).
  - Holding i_step high grants no further cycles.
  - A step that hits HALT enters DRAIN; DRAIN then completes autonomously.
  - i_step is ignored when i_enable=1.
- Not defined: i_step is unused and the pipeline advances only under i_enable; no edge register is synthesized.

Test Plan:
- Reset, then i_enable=1 with no hazards for 10 cycles -> state IDLE->RUN; o_pc_we=o_ifid_we=o_pipe_en=1; o_cycle_cnt=10.
- i_ex_mem_read=1, i_ex_rt=5, i_id_rs=5 for one cycle -> o_pc_we=0, o_ifid_we=0, o_idex_flush=1 that cycle. Same stimulus with i_ex_rt=0, or with i_id_rt=5 and i_id_uses_rt=0 -> no stall.
- i_ex_redirect=1 together with the load-use condition and i_id_halt=1 -> o_ifid_flush=o_idex_flush=1, o_pc_we=1, state stays RUN.
- i_id_halt=1 in RUN (DRAIN_CYCLES=3) -> DRAIN for 3 cycles with o_pipe_en=1, then HALTED with o_halted=1 and o_cycle_cnt frozen; i_enable toggles have no effect. Reset during DRAIN -> IDLE next edge with o_cycle_cnt=0.
- i_enable=0 in RUN for 5 cycles -> all enables 0, o_cycle_cnt unchanged. Raise i_enable=1 -> resumes.
- SEQ_STEP_EN defined, i_enable=0, i_step held high for 4 cycles -> exactly one cycle with o_pc_we=1 and o_cycle_cnt +1. Without SEQ_STEP_EN, the same stimulus -> no advance.
